// File: rtl/mult_seq_fast.sv
// Sequential A x B multiplier: one nonzero A-digit x B-word partial product per cycle,
// zero digits/words skipped, optional two's-complement mode with a final sign fix.
module mult_seq_fast #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32,
    parameter int A_DIG   = 8,
    parameter int B_DIG   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       is_signed,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       busy,
    output logic                       done,
    output logic [A_WIDTH+B_WIDTH-1:0] product
);

    localparam int NA = A_WIDTH / A_DIG;
    localparam int NB = B_WIDTH / B_DIG;
    localparam int P  = A_WIDTH + B_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic [A_WIDTH-1:0] a_mag, a_mag_in;
    logic [B_WIDTH-1:0] b_mag, b_mag_in;
    logic               neg;
    logic [NA-1:0]      a_mask, a_mask_in;
    logic [NA-1:0]      a_pend, a_pend_clr, a_pend_nxt;
    logic [NB-1:0]      b_mask_in, b_pend, b_pend_nxt;
    logic               has_pair, last_pair;
    int                 a_sh, b_sh;
    logic [A_DIG-1:0]   a_digit;
    logic [B_DIG-1:0]   b_word;
    logic [P-1:0]       partial, addend, product_neg;

    // The most-negative input negates to itself, which read unsigned is exactly 2^(W-1).
    assign a_mag_in = (is_signed && a[A_WIDTH-1]) ? (~a + A_WIDTH'(1)) : a;
    assign b_mag_in = (is_signed && b[B_WIDTH-1]) ? (~b + B_WIDTH'(1)) : b;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        a_mask_in = '0;
        b_mask_in = '0;
        for (int i = 0; i < NA; i++) a_mask_in[i] = |a_mag_in[i*A_DIG +: A_DIG];
        for (int j = 0; j < NB; j++) b_mask_in[j] = |b_mag_in[j*B_DIG +: B_DIG];
    end

    assign has_pair = (|a_mask_in) && (|b_mask_in);

    // Lowest pending digit and lowest pending word name the pair being accumulated.
    always_comb begin
        a_sh = 0;
        b_sh = 0;
        for (int i = NA - 1; i >= 0; i--) if (a_pend[i]) a_sh = i * A_DIG;
        for (int j = NB - 1; j >= 0; j--) if (b_pend[j]) b_sh = j * B_DIG;
    end

    assign a_digit = A_DIG'(a_mag >> a_sh);
    assign b_word  = B_DIG'(b_mag >> b_sh);
    assign partial = P'(a_digit) * P'(b_word);
    assign addend  = partial << (a_sh + b_sh);

    // Retire the current digit; once a word's digits are exhausted, retire the word and
    // reload the digit list for the next word.
    assign a_pend_clr = a_pend & (a_pend - NA'(1));

    always_comb begin
        a_pend_nxt = a_pend_clr;
        b_pend_nxt = b_pend;
        if (a_pend_clr == '0) begin
            a_pend_nxt = a_mask;
            b_pend_nxt = b_pend & (b_pend - NB'(1));
        end
    end

    assign last_pair   = (b_pend_nxt == '0);
    assign product_neg = ~product + P'(1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = has_pair ? MULT : FIX;
            MULT:    if (last_pair) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_mag   <= '0;
            b_mag   <= '0;
            neg     <= 1'b0;
            a_mask  <= '0;
            a_pend  <= '0;
            b_pend  <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_mag   <= a_mag_in;
                        b_mag   <= b_mag_in;
                        neg     <= is_signed & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
                        a_mask  <= a_mask_in;
                        a_pend  <= a_mask_in;
                        b_pend  <= b_mask_in;
                        product <= '0;
                    end
                end
                MULT: begin
                    product <= product + addend;
                    a_pend  <= a_pend_nxt;
                    b_pend  <= b_pend_nxt;
                end
                FIX: begin
                    if (neg) product <= product_neg;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_seq_fast.sv
// Self-checking bench for mult_seq_fast: directed cases, handshake and reset abort on the
// default instance, plus randomised back-to-back operations on a default and a small instance.
module tb_mult_seq_fast;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start0 = 1'b0, is_signed0 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0;
    logic        busy0, done0;
    logic [63:0] product0;

    logic        start1 = 1'b0, is_signed1 = 1'b0;
    logic [15:0] a1 = '0;
    logic [23:0] b1 = '0;
    logic        busy1, done1;
    logic [39:0] product1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mult_seq_fast dut0 (
        .clk(clk), .reset(reset), .start(start0), .is_signed(is_signed0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .product(product0)
    );

    mult_seq_fast #(.A_WIDTH(16), .B_WIDTH(24), .A_DIG(4), .B_DIG(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .is_signed(is_signed1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .product(product1)
    );

    function automatic logic get_done(input bit alt);
        return alt ? done1 : done0;
    endfunction

    function automatic logic get_busy(input bit alt);
        return alt ? busy1 : busy0;
    endfunction

    function automatic logic [63:0] get_prod(input bit alt);
        return alt ? {24'd0, product1} : product0;
    endfunction

    // Reference: exact wide signed/unsigned product truncated to P bits; latency from digit counts.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input bit s,
                                   input int aw, input int bw, input int ad, input int bd);
        exp_t e;
        logic signed [129:0] ax, bx, px;
        logic [63:0] am, bm, pmask;
        int na_nz, nb_nz;
        ax = $signed({66'd0, a});
        bx = $signed({66'd0, b});
        if (s && a[aw-1]) ax = ax - (130'sd1 <<< aw);
        if (s && b[bw-1]) bx = bx - (130'sd1 <<< bw);
        px = ax * bx;
        pmask = (aw + bw >= 64) ? '1 : ((64'd1 << (aw + bw)) - 64'd1);
        e.prod = px[63:0] & pmask;
        am = (ax < 0) ? 64'(-ax) : 64'(ax);
        bm = (bx < 0) ? 64'(-bx) : 64'(bx);
        na_nz = 0;
        nb_nz = 0;
        for (int i = 0; i < aw / ad; i++)
            if (((am >> (i * ad)) & ((64'd1 << ad) - 64'd1)) != 0) na_nz++;
        for (int j = 0; j < bw / bd; j++)
            if (((bm >> (j * bd)) & ((64'd1 << bd) - 64'd1)) != 0) nb_nz++;
        e.lat = na_nz * nb_nz + 1;
        return e;
    endfunction

    function automatic logic [63:0] sparse(input logic [63:0] v, input int w, input int d);
        logic [63:0] r;
        r = v & ((64'd1 << w) - 64'd1);
        for (int i = 0; i < w / d; i++)
            if ($urandom_range(0, 2) == 0) r = r & ~(((64'd1 << d) - 64'd1) << (i * d));
        return r;
    endfunction

    task automatic push_exp(input logic [63:0] prod, input int lat);
        exp_t e;
        e.prod = prod;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic push_model(input bit alt, input logic [63:0] a, input logic [63:0] b, input bit s);
        if (alt) sb.push_back(model(a, b, s, 16, 24, 4, 8));
        else     sb.push_back(model(a, b, s, 32, 32, 8, 16));
    endtask

    // Called at a falling edge; returns at the falling edge just after the accepting edge.
    task automatic start_op(input bit alt, input logic [63:0] a, input logic [63:0] b, input bit s);
        if (alt) begin
            a1 = a[15:0]; b1 = b[23:0]; is_signed1 = s; start1 = 1'b1;
        end else begin
            a0 = a[31:0]; b0 = b[31:0]; is_signed0 = s; start0 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input bit alt, input int lat0, input int bc0,
                             output int lat, output int bc);
        lat = lat0;
        bc  = bc0;
        while (!get_done(alt) && lat < 64) begin
            if (get_busy(alt)) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input bit alt, input string name, input int lat, input int bc);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s: no expected result queued", name);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (get_prod(alt) !== e.prod)
            $display("FAIL %s product: got %h expected %h", name, get_prod(alt), e.prod);
        else n_pass++;
        n_checks++;
        if (lat !== e.lat)
            $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
        else n_pass++;
        n_checks++;
        if (bc !== e.lat)
            $display("FAIL %s busy cycles: got %0d expected %0d", name, bc, e.lat);
        else n_pass++;
        n_checks++;
        if (get_busy(alt) !== 1'b0)
            $display("FAIL %s busy with done: got %b expected 0", name, get_busy(alt));
        else n_pass++;
    endtask

    task automatic run_op(input bit alt, input string name,
                          input logic [63:0] a, input logic [63:0] b, input bit s);
        int lat, bc;
        start_op(alt, a, b, s);
        wait_done(alt, 0, 0, lat, bc);
        check_result(alt, name, lat, bc);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy0, done0, product0} !== 66'd0)
            $display("FAIL reset0: got busy=%b done=%b product=%h expected all 0", busy0, done0, product0);
        else n_pass++;
        n_checks++;
        if ({busy1, done1, product1} !== 42'd0)
            $display("FAIL reset1: got busy=%b done=%b product=%h expected all 0", busy1, done1, product1);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy0, done0} !== 2'b00)
            $display("FAIL idle after reset: got busy=%b done=%b expected 00", busy0, done0);
        else n_pass++;
    endtask

    task automatic test_unsigned_full();
        push_exp(64'hFFFF_FFFE_0000_0001, 9);
        run_op(0, "unsigned_full", 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_skipping();
        push_exp(64'h2FD, 2);
        run_op(0, "skip_one_pair", 64'h0000_00FF, 64'h0000_0003, 1'b0);
        // 0x12000034 * (5 << 16): digits 0 and 3 against word 1
        push_exp(64'h0000_5A00_0104_0000, 3);
        run_op(0, "skip_two_pairs", 64'h1200_0034, 64'h0005_0000, 1'b0);
    endtask

    task automatic test_zero();
        push_exp(64'h0, 1);
        run_op(0, "zero_operand", 64'h0, 64'hDEAD_BEEF, 1'b1);
    endtask

    task automatic test_signed();
        push_exp(64'hFFFF_FFFF_FFFF_FFFA, 2);
        run_op(0, "signed_neg2x3", 64'hFFFF_FFFE, 64'h0000_0003, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done0, product0} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFA})
            $display("FAIL idle hold: got done=%b product=%h expected 0/fffffffffffffffa", done0, product0);
        else n_pass++;
        push_exp(64'h4000_0000_0000_0000, 2);
        run_op(0, "signed_minmin", 64'h8000_0000, 64'h8000_0000, 1'b1);
    endtask

    task automatic test_handshake();
        int lat, bc;
        push_exp(64'hFFFF_FFFE_0000_0001, 9);
        start_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
        lat = 0;
        bc  = 0;
        a0 = 32'h0000_0001; b0 = 32'h0000_0001; is_signed0 = 1'b1; start0 = 1'b1;
        repeat (3) begin
            if (busy0) bc++;
            @(negedge clk);
            lat++;
        end
        start0 = 1'b0;
        wait_done(0, lat, bc, lat, bc);
        check_result(0, "start_while_busy", lat, bc);
        // Restart in the done cycle: product clears and done drops at that edge.
        push_model(0, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0);
        start_op(0, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0);
        n_checks++;
        if ({done0, busy0, product0} !== {1'b0, 1'b1, 64'h0})
            $display("FAIL restart in done: got done=%b busy=%b product=%h expected 0/1/0", done0, busy0, product0);
        else n_pass++;
        wait_done(0, 0, 0, lat, bc);
        check_result(0, "restart_result", lat, bc);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        start_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy0, done0, product0} !== 66'd0)
            $display("FAIL reset mid-op: got busy=%b done=%b product=%h expected all 0", busy0, done0, product0);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done0 || busy0) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0)
            $display("FAIL aborted op: got activity=%b expected 0", seen_done);
        else n_pass++;
        push_exp(64'hFFFF_FFFE_0000_0001, 9);
        run_op(0, "after_reset", 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    endtask

    // Back-to-back random operations, each new start issued in the previous done cycle.
    task automatic test_back_to_back(input bit alt, input int count);
        int lat, bc;
        logic [63:0] ra, rb;
        bit rs;
        for (int k = 0; k < count; k++) begin
            ra = alt ? sparse({32'd0, $urandom}, 16, 4) : sparse({32'd0, $urandom}, 32, 8);
            rb = alt ? sparse({32'd0, $urandom}, 24, 8) : sparse({32'd0, $urandom}, 32, 16);
            if (k == 0) ra = alt ? 64'h8000 : 64'h8000_0000;
            if (k == 1) rb = alt ? 64'hFF_FFFF : 64'hFFFF_FFFF;
            rs = 1'($urandom_range(0, 1));
            push_model(alt, ra, rb, rs);
            start_op(alt, ra, rb, rs);
            wait_done(alt, 0, 0, lat, bc);
            check_result(alt, alt ? "random_small" : "random_default", lat, bc);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unsigned_full();
        test_skipping();
        test_zero();
        test_signed();
        test_handshake();
        test_reset_mid();
        test_back_to_back(0, 30);
        test_back_to_back(1, 30);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
